// File: rtl/ro_entropy_pkg.sv
// Shared types and default constants for the ring-oscillator entropy collector.
package ro_entropy_pkg;

   typedef enum logic {
      VN_IDLE       = 1'b0,
      VN_HAVE_FIRST = 1'b1
   } vn_state_t;

   localparam int DEF_NUM_CH    = 4;
   localparam int DEF_WORD_W    = 8;
   localparam int DEF_DIV_W     = 8;
   localparam int DEF_REP_LIMIT = 32;

endpackage

// File: rtl/vn_debiaser.sv
// Von Neumann debiaser: samples pairs of bits on tick, emits the first bit of
// an unequal pair (01 -> 0, 10 -> 1) and discards equal pairs.
module vn_debiaser
   import ro_entropy_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick,
   input  logic bit_in,
   output logic bit_valid,
   output logic bit_out
);

   vn_state_t state;
   logic      first_bit;

   // Remember the first sample of a pair and close the pair on the next tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= VN_IDLE;
         first_bit <= 1'b0;
      end else if (clr) begin
         state <= VN_IDLE;
      end else if (tick) begin
         if (state == VN_IDLE) begin
            state     <= VN_HAVE_FIRST;
            first_bit <= bit_in;
         end else begin
            state <= VN_IDLE;
         end
      end
   end

   assign bit_valid = !clr && tick && (state == VN_HAVE_FIRST) && (first_bit != bit_in);
   assign bit_out   = first_bit;

endmodule

// File: rtl/ro_entropy_collector.sv
// Ring-oscillator entropy collector: synchronises and XOR-combines the
// oscillator bits, samples them on a programmable tick, debiases pairs and
// packs the surviving bits into words behind a valid/ready handshake.
// Optional repetition-count health test enabled by defining RO_HEALTH_TEST_EN.
module ro_entropy_collector
   import ro_entropy_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int WORD_W    = DEF_WORD_W,
   parameter int DIV_W     = DEF_DIV_W,
   parameter int REP_LIMIT = DEF_REP_LIMIT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] raw_in,
   input  logic [DIV_W-1:0]  sample_div,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              health_fail
);

   localparam int               CNT_W    = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

   logic [NUM_CH-1:0] sync_meta;
   logic [NUM_CH-1:0] sync_q;
   logic              comb_bit;
   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic              vn_clr;
   logic              vn_valid;
   logic              vn_bit;
   logic              emit;
   logic              word_full;
   logic              can_load;
   logic              load_word;
   logic [CNT_W-1:0]  bit_cnt;
   logic [WORD_W-2:0] acc;
   logic [WORD_W-1:0] next_word;

   // Two-flop synchroniser for every asynchronous oscillator input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= raw_in;
         sync_q    <= sync_meta;
      end
   end

   assign comb_bit = ^(sync_q & ch_en);
   assign tick     = en && (div_cnt >= sample_div);

   // Sample divider: counts 0..sample_div, parked at 0 while collection is off
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (!en || tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign vn_clr = !en;

   vn_debiaser u_vn (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (vn_clr),
      .tick      (tick),
      .bit_in    (comb_bit),
      .bit_valid (vn_valid),
      .bit_out   (vn_bit)
   );

   assign emit      = vn_valid && !health_fail;
   assign word_full = (bit_cnt == LAST_BIT);
   assign can_load  = !out_valid || out_ready;
   assign load_word = emit && word_full && can_load;
   assign next_word = {acc, vn_bit};

   // Shift debiased bits in; a completing bit that cannot be delivered is dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         bit_cnt <= '0;
      end else if (!en) begin
         bit_cnt <= '0;
      end else if (emit) begin
         if (!word_full) begin
            acc     <= next_word[WORD_W-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
         end else if (can_load) begin
            acc     <= next_word[WORD_W-2:0];
            bit_cnt <= '0;
         end
      end
   end

   // Output word register with handshake and sticky overrun flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load_word) begin
            out_data  <= next_word;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (emit && word_full && !can_load) begin
            overrun <= 1'b1;
         end
      end
   end

`ifdef RO_HEALTH_TEST_EN
   localparam logic [7:0] RUN_LIMIT = 8'(REP_LIMIT);

   logic [7:0] run_cnt;
   logic [7:0] run_next;
   logic       last_bit;

   assign run_next = (comb_bit != last_bit) ? 8'd1 :
                     (run_cnt == 8'hFF)     ? run_cnt : run_cnt + 8'd1;

   // Repetition-count test on every sampled bit; failure is sticky until reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt     <= '0;
         last_bit    <= 1'b0;
         health_fail <= 1'b0;
      end else if (tick) begin
         run_cnt  <= run_next;
         last_bit <= comb_bit;
         if (run_next >= RUN_LIMIT) begin
            health_fail <= 1'b1;
         end
      end
   end
`else
   assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_ro_entropy_collector.sv
// Self-checking bench for ro_entropy_collector: directed pair streams plus
// randomized traffic compared against a behavioural model.
module tb_ro_entropy_collector;

   localparam int WORD_W = 8;
`ifdef RO_HEALTH_TEST_EN
   localparam int REP_LIMIT = 32;
`endif

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] ch_en;
   logic [3:0] raw_in;
   logic [7:0] sample_div;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       overrun;
   logic       health_fail;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] raw_hist[$];
   int         m_en_cycles;
   int         m_nbits;
   int         m_acc;
   logic       m_have_first;
   logic       m_first;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_overrun;
   logic       m_health;
`ifdef RO_HEALTH_TEST_EN
   int         m_run;
   logic       m_last;
`endif

   logic stream[$];
   logic pre_last_valid;

   ro_entropy_collector #(
      .NUM_CH(4), .WORD_W(8), .DIV_W(8), .REP_LIMIT(32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .ch_en       (ch_en),
      .raw_in      (raw_in),
      .sample_div  (sample_div),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun),
      .health_fail (health_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic model_reset();
      raw_hist     = {4'h0, 4'h0};
      m_en_cycles  = 0;
      m_nbits      = 0;
      m_acc        = 0;
      m_have_first = 1'b0;
      m_first      = 1'b0;
      m_data       = 8'h00;
      m_valid      = 1'b0;
      m_overrun    = 1'b0;
      m_health     = 1'b0;
`ifdef RO_HEALTH_TEST_EN
      m_run        = 0;
      m_last       = 1'b0;
`endif
   endtask

   // Behavioural model: bits sampled two edges after they are driven, paired,
   // debiased and packed MSB-oldest into words.
   task automatic model_edge(input logic en_v, input logic [3:0] ch_v, input logic [3:0] raw_v,
                             input logic [7:0] div_v, input logic rdy_v);
      logic b, tk, emitted, ebit, old_valid, old_health, loaded;
      b = ^(raw_hist[0] & ch_v);
      raw_hist.push_back(raw_v);
      void'(raw_hist.pop_front());
      tk = en_v && ((m_en_cycles % (int'(div_v) + 1)) == int'(div_v));
      m_en_cycles = en_v ? m_en_cycles + 1 : 0;
      old_valid  = m_valid;
      old_health = m_health;
      emitted = 1'b0;
      ebit    = 1'b0;
      loaded  = 1'b0;
      if (!en_v) begin
         m_have_first = 1'b0;
         m_nbits      = 0;
      end else if (tk) begin
`ifdef RO_HEALTH_TEST_EN
         m_run  = (m_run > 0 && b == m_last) ? m_run + 1 : 1;
         m_last = b;
         if (m_run >= REP_LIMIT) m_health = 1'b1;
`endif
         if (!m_have_first) begin
            m_first      = b;
            m_have_first = 1'b1;
         end else begin
            m_have_first = 1'b0;
            if (m_first != b) begin
               emitted = 1'b1;
               ebit    = m_first;
            end
         end
      end
      if (emitted && !old_health) begin
         if (m_nbits == WORD_W - 1) begin
            if (!old_valid || rdy_v) begin
               m_data  = 8'((m_acc * 2 + int'(ebit)) % 256);
               loaded  = 1'b1;
               m_nbits = 0;
            end else begin
               m_overrun = 1'b1;
            end
         end else begin
            m_acc   = (m_acc * 2 + int'(ebit)) % 256;
            m_nbits = m_nbits + 1;
         end
      end
      if (loaded) m_valid = 1'b1;
      else if (old_valid && rdy_v) m_valid = 1'b0;
   endtask

   task automatic step(input logic en_v, input logic [3:0] ch_v, input logic [3:0] raw_v,
                       input logic [7:0] div_v, input logic rdy_v);
      @(negedge clk);
      en         = en_v;
      ch_en      = ch_v;
      raw_in     = raw_v;
      sample_div = div_v;
      out_ready  = rdy_v;
      @(posedge clk);
      model_edge(en_v, ch_v, raw_v, div_v, rdy_v);
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en = 1'b0; ch_en = 4'h0; raw_in = 4'h0; sample_div = 8'h00; out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic add_pairs(input logic a, input logic b, input int count);
      for (int k = 0; k < count; k++) begin
         stream.push_back(a);
         stream.push_back(b);
      end
   endtask

   // Plays stream on raw_in[0], each bit held sample_div+1 cycles, with en
   // lagging by the synchroniser depth so ticks land on stream bits.
   task automatic play_stream(input int ready_at, input logic [7:0] div_v);
      int n, hold, last, idx;
      logic r0;
      n    = stream.size();
      hold = int'(div_v) + 1;
      last = n * hold + 1;
      for (int i = 0; i <= last; i++) begin
         idx = i / hold;
         r0  = (idx < n) ? stream[idx] : 1'b0;
         step(i >= 2, 4'b0001, {3'($urandom_range(0, 7)), r0}, div_v, i == ready_at);
         if (i == last - 1) pre_last_valid = out_valid;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      step(1'b0, 4'h0, 4'h0, 8'h00, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
      n_tests++;
      if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data: got %h want 00", out_data); end
      n_tests++;
      if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
      n_tests++;
      if (health_fail !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_health: got %b want 0", health_fail); end
   endtask

   task automatic test_pairs();
      apply_reset();
      stream = {};
      add_pairs(0, 1, 1); add_pairs(1, 0, 2); add_pairs(0, 1, 2); add_pairs(1, 0, 2); add_pairs(0, 1, 1);
      play_stream(-1, 8'd0);
      n_tests++;
      if (pre_last_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pairs_early_valid: got %b want 0", pre_last_valid); end
      n_tests++;
      if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pairs_valid: got %b want 1", out_valid); end
      n_tests++;
      if (out_data !== 8'b01100110) begin n_fail++; $display("[TB] FAIL pairs_data: got %b want 01100110", out_data); end
      n_tests++;
      if (out_data !== m_data) begin n_fail++; $display("[TB] FAIL pairs_model: got %h want %h", out_data, m_data); end
      step(1'b0, 4'h1, 4'h0, 8'd0, 1'b0);
   endtask

   task automatic test_discard_equal();
      apply_reset();
      stream = {};
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) add_pairs(0, 0, 1);
         else add_pairs(1, 1, 1);
         add_pairs(1, 0, 1);
      end
      play_stream(-1, 8'd0);
      n_tests++;
      if (pre_last_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL discard_early_valid: got %b want 0", pre_last_valid); end
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
         n_fail++; $display("[TB] FAIL discard_word: got v=%b d=%h want v=1 d=ff", out_valid, out_data);
      end
   endtask

   task automatic test_overrun();
      apply_reset();
      stream = {};
      add_pairs(1, 0, 8); add_pairs(0, 1, 8);
      play_stream(-1, 8'd0);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'hFF) begin
         n_fail++; $display("[TB] FAIL overrun_hold: got v=%b d=%h want v=1 d=ff", out_valid, out_data);
      end
      n_tests++;
      if (overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL overrun_flag: got %b want 1", overrun); end
      apply_reset();
      stream = {};
      add_pairs(1, 0, 8); add_pairs(0, 1, 9);
      play_stream(int'(stream.size()) + 1, 8'd0);
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h00 || overrun !== 1'b1) begin
         n_fail++; $display("[TB] FAIL overrun_reload: got v=%b d=%h o=%b want v=1 d=00 o=1", out_valid, out_data, overrun);
      end
      n_tests++;
      if (out_valid !== m_valid || out_data !== m_data) begin
         n_fail++; $display("[TB] FAIL overrun_model: got v=%b d=%h want v=%b d=%h", out_valid, out_data, m_valid, m_data);
      end
   endtask

   task automatic test_divider();
      apply_reset();
      stream = {};
      add_pairs(1, 0, 3);
      play_stream(-1, 8'd3);
      step(1'b0, 4'h1, 4'h0, 8'd3, 1'b0);
      stream = {};
      add_pairs(0, 1, 8);
      play_stream(-1, 8'd3);
      n_tests++;
      if (pre_last_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL div_early_valid: got %b want 0", pre_last_valid); end
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 8'h00) begin
         n_fail++; $display("[TB] FAIL div_fresh_word: got v=%b d=%h want v=1 d=00", out_valid, out_data);
      end
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         step(!(c >= 150 && c < 153), 4'b0001, 4'($urandom_range(0, 15)), 8'd3, 1'($urandom_range(0, 1)));
         n_tests++;
         if ({out_valid, out_data, overrun} !== {m_valid, m_data, m_overrun}) begin
            n_fail++;
            $display("[TB] FAIL div_random cyc %0d: got v=%b d=%h o=%b want v=%b d=%h o=%b",
                     c, out_valid, out_data, overrun, m_valid, m_data, m_overrun);
         end
      end
   endtask

   task automatic test_health();
      int   first_fail;
      logic ever_valid;
      apply_reset();
      first_fail = -1;
      ever_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 4'b0001, 4'h0, 8'd0, 1'b0);
         if (health_fail === 1'b1 && first_fail < 0) first_fail = i;
         if (out_valid !== 1'b0) ever_valid = 1'b1;
      end
`ifdef RO_HEALTH_TEST_EN
      n_tests++;
      if (first_fail != 31) begin n_fail++; $display("[TB] FAIL health_tick: got step %0d want 31", first_fail); end
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 8'd0, 1'b0);
         if (out_valid !== 1'b0) ever_valid = 1'b1;
      end
      n_tests++;
      if (health_fail !== m_health) begin n_fail++; $display("[TB] FAIL health_model: got %b want %b", health_fail, m_health); end
`else
      n_tests++;
      if (first_fail != -1) begin n_fail++; $display("[TB] FAIL health_off: got step %0d want none", first_fail); end
`endif
      n_tests++;
      if (ever_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL health_no_word: got %b want 0", ever_valid); end
   endtask

   task automatic test_random();
      logic [3:0] ch;
      logic [7:0] dv;
      logic       e;
      apply_reset();
      ch = 4'b1111;
      dv = 8'd0;
      for (int c = 0; c < 1500; c++) begin
         e = ($urandom_range(0, 63) != 0);
         if (!e) begin
            ch = 4'($urandom_range(1, 15));
            dv = 8'($urandom_range(0, 3));
         end
         step(e, ch, 4'($urandom_range(0, 15)), dv, 1'($urandom_range(0, 1)));
         n_tests++;
         if ({out_valid, out_data, overrun, health_fail} !== {m_valid, m_data, m_overrun, m_health}) begin
            n_fail++;
            $display("[TB] FAIL random cyc %0d: got v=%b d=%h o=%b h=%b want v=%b d=%h o=%b h=%b",
                     c, out_valid, out_data, overrun, health_fail, m_valid, m_data, m_overrun, m_health);
         end
      end
   endtask

   task automatic test_async_reset();
      int c;
      apply_reset();
      c = 0;
      while (!(m_valid && m_nbits > 0) && c < 500) begin
         step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 8'd0, 1'b0);
         c++;
      end
      n_tests++;
      if (!(m_valid && m_nbits > 0)) begin
         n_fail++; $display("[TB] FAIL async_setup: got no pending word within %0d cycles", c);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, out_data, overrun, health_fail} !== 11'b0) begin
         n_fail++; $display("[TB] FAIL async_reset: got v=%b d=%h o=%b h=%b want all 0",
                            out_valid, out_data, overrun, health_fail);
      end
      en = 1'b0; raw_in = 4'h0; out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 150; k++) begin
         step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 8'd0, 1'($urandom_range(0, 1)));
         n_tests++;
         if ({out_valid, out_data, overrun} !== {m_valid, m_data, m_overrun}) begin
            n_fail++;
            $display("[TB] FAIL after_reset cyc %0d: got v=%b d=%h o=%b want v=%b d=%h o=%b",
                     k, out_valid, out_data, overrun, m_valid, m_data, m_overrun);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0; ch_en = 4'h0; raw_in = 4'h0; sample_div = 8'h00; out_ready = 1'b0;
      pre_last_valid = 1'b0;
      model_reset();
      test_reset();
      test_pairs();
      test_discard_equal();
      test_overrun();
      test_divider();
      test_random();
      test_async_reset();
      test_health();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
